// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_arb_pkg
// Description : Shared types and helpers for the instruction-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

  // Ownership of the single outstanding response slot
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RSP_F = 2'd1,
    RSP_D = 2'd2
  } state_e;

  // Which requester is granted the memory this cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_F    = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;

  // A byte address is usable only when word aligned and inside the memory.
  // Callers zero-extend their address to 64 bits.
  function automatic logic addr_legal(input logic [63:0] byte_addr,
                                      input int unsigned mem_words);
    return (byte_addr[1:0] == 2'b00) && ((byte_addr >> 2) < {32'd0, mem_words});
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_if
// Description : Request/response handshakes of ports F and D plus the
//               instruction-memory bus, bundled for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  f_req_valid;
  logic                  f_req_ready;
  logic [ADDR_WIDTH-1:0] f_req_addr;
  logic                  f_rsp_valid;
  logic                  f_rsp_ready;
  logic [DATA_WIDTH-1:0] f_rsp_data;
  logic                  f_rsp_err;

  logic                  d_req_valid;
  logic                  d_req_ready;
  logic                  d_req_we;
  logic [ADDR_WIDTH-1:0] d_req_addr;
  logic [DATA_WIDTH-1:0] d_req_wdata;
  logic                  d_rsp_valid;
  logic                  d_rsp_ready;
  logic [DATA_WIDTH-1:0] d_rsp_data;
  logic                  d_rsp_err;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  f_req_valid, f_req_addr, f_rsp_ready,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
    input  mem_rdata,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_addr, mem_we, mem_wdata
  );

  // Requesters and memory view
  modport master (
    output f_req_valid, f_req_addr, f_rsp_ready,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
    output mem_rdata,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : imem_arb_pick
// Description : Combinational grant selection. F has fixed priority unless D
//               has waited STARVE_LIMIT consecutive F grants.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arb_pick
  import imem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             f_valid_i,
  input  logic             d_valid_i,
  input  logic             free_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output gnt_e             gnt_o
);

  // Priority select, only when the response slot is free
  always_comb begin
    gnt_o = GNT_NONE;
    if (free_i) begin
      if (d_valid_i && (starve_cnt_i == CNT_W'(STARVE_LIMIT))) begin
        gnt_o = GNT_D;
      end else if (f_valid_i) begin
        gnt_o = GNT_F;
      end else if (d_valid_i) begin
        gnt_o = GNT_D;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Shares one word-addressed instruction memory between the
//               fetch port (F) and the debug/loader port (D). One access is
//               outstanding at a time; the read data is registered into a
//               single response slot owned by the granted port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_SIZE     = 512,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_e                state_q, state_d;
  gnt_e                  gnt;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  free;
  logic                  accept;
  logic                  legal;
  logic                  is_write;
  logic [ADDR_WIDTH-1:0] gnt_addr;

  // The slot frees up in the same cycle the owner takes its response,
  // which is what gives one access per cycle throughput.
  assign free = (state_q == IDLE)
              | ((state_q == RSP_F) & bus.f_rsp_ready)
              | ((state_q == RSP_D) & bus.d_rsp_ready);

  imem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .f_valid_i    (bus.f_req_valid),
    .d_valid_i    (bus.d_req_valid),
    .free_i       (free),
    .starve_cnt_i (starve_q),
    .gnt_o        (gnt)
  );

  // Reset also masks the combinational outputs so every output reads 0
  // while rst is high, even with requests pending.
  assign accept   = (gnt != GNT_NONE) && !rst;
  assign gnt_addr = (gnt == GNT_D) ? bus.d_req_addr : bus.f_req_addr;
  assign legal    = addr_legal(64'(gnt_addr), MEM_SIZE);
  assign is_write = (gnt == GNT_D) && bus.d_req_we;

  assign bus.f_req_ready = (gnt == GNT_F) && !rst;
  assign bus.d_req_ready = (gnt == GNT_D) && !rst;

  assign bus.f_rsp_valid = (state_q == RSP_F);
  assign bus.f_rsp_data  = (state_q == RSP_F) ? rsp_data_q : '0;
  assign bus.f_rsp_err   = (state_q == RSP_F) && rsp_err_q;
  assign bus.d_rsp_valid = (state_q == RSP_D);
  assign bus.d_rsp_data  = (state_q == RSP_D) ? rsp_data_q : '0;
  assign bus.d_rsp_err   = (state_q == RSP_D) && rsp_err_q;

  // Next state, memory drive and response capture for the accept cycle
  always_comb begin
    state_d       = state_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (accept) begin
      bus.mem_addr  = gnt_addr;
      bus.mem_wdata = bus.d_req_wdata;
      bus.mem_we    = is_write && legal;
      rsp_data_d    = (legal && !is_write) ? bus.mem_rdata : '0;
      rsp_err_d     = !legal;
      state_d       = (gnt == GNT_D) ? RSP_D : RSP_F;
    end else if (free) begin
      state_d = IDLE;
    end
  end

  // Count consecutive F grants that D has watched go by
  always_comb begin
    starve_d = starve_q;
    if (!bus.d_req_valid || (gnt == GNT_D)) begin
      starve_d = '0;
    end else if ((gnt == GNT_F) && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // State, response slot and starvation counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_arbiter
// Description : Self-checking bench for imem_arbiter: directed scenarios plus
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MSZ = 512;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  imem_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .MEM_SIZE     (MSZ),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int we_cnt   = 0;

  logic [DW-1:0] tb_mem  [MSZ];
  logic [DW-1:0] ref_mem [MSZ];

  // Model state: owner 0 = none, 1 = F, 2 = D
  int            m_owner;
  logic [DW-1:0] m_data;
  logic          m_err;
  int            m_starve;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Memory with combinational read and write on the clock edge
  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_addr[AW-1:2] < MSZ) bus.mem_rdata = tb_mem[bus.mem_addr[10:2]];
  end

  initial begin
    for (int i = 0; i < MSZ; i++) tb_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_we) begin
        we_cnt++;
        if (bus.mem_addr[AW-1:2] < MSZ) tb_mem[bus.mem_addr[10:2]] <= bus.mem_wdata;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_f_req_ready"}, bus.f_req_ready, 0);
    chk({tag, "_d_req_ready"}, bus.d_req_ready, 0);
    chk({tag, "_f_rsp_valid"}, bus.f_rsp_valid, 0);
    chk({tag, "_d_rsp_valid"}, bus.d_rsp_valid, 0);
    chk({tag, "_f_rsp_data"},  bus.f_rsp_data,  0);
    chk({tag, "_d_rsp_data"},  bus.d_rsp_data,  0);
    chk({tag, "_rsp_err"},     {bus.f_rsp_err, bus.d_rsp_err}, 0);
    chk({tag, "_mem_we"},      bus.mem_we,      0);
    chk({tag, "_mem_addr"},    bus.mem_addr,    0);
    chk({tag, "_mem_wdata"},   bus.mem_wdata,   0);
  endtask

  // Predict this cycle's outputs from the transaction model, then advance it
  task automatic model_check();
    int            gnt;
    bit            free, legal, wr;
    logic [AW-1:0] a;
    free = (m_owner == 0) || (m_owner == 1 && bus.f_rsp_ready) || (m_owner == 2 && bus.d_rsp_ready);
    gnt  = 0;
    if (free) begin
      if (bus.d_req_valid && m_starve == LIM) gnt = 2;
      else if (bus.f_req_valid)               gnt = 1;
      else if (bus.d_req_valid)               gnt = 2;
    end
    a     = (gnt == 2) ? bus.d_req_addr : bus.f_req_addr;
    legal = (a % 4 == 0) && (a / 4 < MSZ);
    wr    = (gnt == 2) && bus.d_req_we;
    chk("f_req_ready", bus.f_req_ready, gnt == 1);
    chk("d_req_ready", bus.d_req_ready, gnt == 2);
    chk("f_rsp_valid", bus.f_rsp_valid, m_owner == 1);
    chk("d_rsp_valid", bus.d_rsp_valid, m_owner == 2);
    if (m_owner == 1) begin
      chk("f_rsp_data", bus.f_rsp_data, m_data);
      chk("f_rsp_err",  bus.f_rsp_err,  m_err);
    end
    if (m_owner == 2) begin
      chk("d_rsp_data", bus.d_rsp_data, m_data);
      chk("d_rsp_err",  bus.d_rsp_err,  m_err);
    end
    chk("mem_we",    bus.mem_we,    wr && legal);
    chk("mem_addr",  bus.mem_addr,  (gnt != 0) ? a : 32'd0);
    chk("mem_wdata", bus.mem_wdata, (gnt != 0) ? bus.d_req_wdata : 32'd0);
    if (gnt != 0) begin
      m_owner = gnt;
      m_err   = !legal;
      m_data  = '0;
      if (legal && !wr) m_data = ref_mem[int'(a >> 2)];
      if (legal && wr)  ref_mem[int'(a >> 2)] = bus.d_req_wdata;
    end else if (free) begin
      m_owner = 0;
    end
    if (!bus.d_req_valid || gnt == 2) m_starve = 0;
    else if (gnt == 1 && m_starve < LIM) m_starve++;
  endtask

  task automatic cycle(input logic fv, input logic [AW-1:0] fa, input logic fr,
                       input logic dv, input logic dwe, input logic [AW-1:0] da,
                       input logic [DW-1:0] dwd, input logic dr);
    @(posedge clk);
    #1;
    bus.f_req_valid = fv;  bus.f_req_addr = fa;  bus.f_rsp_ready = fr;
    bus.d_req_valid = dv;  bus.d_req_we   = dwe; bus.d_req_addr  = da;
    bus.d_req_wdata = dwd; bus.d_rsp_ready = dr;
    @(negedge clk);
    model_check();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return AW'($urandom_range(0, MSZ - 1) * 4 + $urandom_range(1, 3));
    if (r == 1) return AW'(($urandom_range(0, 63) + MSZ) * 4);
    if (r < 8)  return AW'($urandom_range(0, 15) * 4);
    return AW'($urandom_range(0, MSZ - 1) * 4);
  endfunction

  function automatic int seen_grant();
    return bus.f_req_ready ? 1 : (bus.d_req_ready ? 2 : 0);
  endfunction

  initial begin
    int w0;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_word(i);
    m_owner = 0; m_data = '0; m_err = 1'b0; m_starve = 0;
    bus.f_req_valid = 0; bus.f_req_addr = '0; bus.f_rsp_ready = 0;
    bus.d_req_valid = 0; bus.d_req_we = 0; bus.d_req_addr = '0;
    bus.d_req_wdata = '0; bus.d_rsp_ready = 0;

    // Reset with requests pending: everything must read 0
    repeat (2) @(posedge clk);
    #1;
    bus.f_req_valid = 1; bus.d_req_valid = 1; bus.d_req_we = 1; bus.d_req_wdata = 32'h1234_5678;
    #1;
    check_zero("reset");
    bus.f_req_valid = 0; bus.d_req_valid = 0; bus.d_req_we = 0; bus.d_req_wdata = '0;
    @(negedge clk);
    rst = 0;

    // F read of word 1
    cycle(1, 32'h4, 1, 0, 0, 0, 0, 1);
    chk("t1_f_req_ready", bus.f_req_ready, 1);
    cycle(0, 0, 1, 0, 0, 0, 0, 1);
    chk("t1_f_rsp_valid", bus.f_rsp_valid, 1);
    chk("t1_f_rsp_data",  bus.f_rsp_data, init_word(1));
    chk("t1_f_rsp_err",   bus.f_rsp_err, 0);

    // D write then immediate F read of the same word
    w0 = we_cnt;
    cycle(0, 0, 1, 1, 1, 32'h10, 32'hDEAD_BEEF, 1);
    cycle(1, 32'h10, 1, 0, 0, 0, 0, 1);
    chk("t2_d_rsp_valid", bus.d_rsp_valid, 1);
    chk("t2_d_rsp_data",  bus.d_rsp_data, 0);
    chk("t2_d_rsp_err",   bus.d_rsp_err, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 1);
    chk("t2_f_rsp_data",  bus.f_rsp_data, 32'hDEAD_BEEF);
    chk("t2_we_pulses",   we_cnt - w0, 1);

    // Both ports continuously valid: F,F,F,F,D repeating
    for (int k = 0; k < 10; k++) begin
      cycle(1, AW'($urandom_range(0, 63) * 4), 1, 1, 0, AW'($urandom_range(0, 63) * 4), 0, 1);
      chk("t3_grant", seen_grant(), (k % 5 == 4) ? 2 : 1);
      chk("t3_single_grant", bus.f_req_ready & bus.d_req_ready, 0);
    end

    // Misaligned F read and out-of-range D write
    w0 = we_cnt;
    cycle(1, 32'h802, 1, 0, 0, 0, 0, 1);
    cycle(0, 0, 1, 1, 1, 32'h800, 32'h1234_5678, 1);
    chk("t4_f_err",  bus.f_rsp_err, 1);
    chk("t4_f_data", bus.f_rsp_data, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 1);
    chk("t4_d_err",  bus.d_rsp_err, 1);
    chk("t4_d_data", bus.d_rsp_data, 0);
    chk("t4_no_we",  we_cnt - w0, 0);

    // F response stalled for 5 cycles with D waiting
    cycle(1, 32'h8, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 0, 1, 0, 32'h20, 0, 1);
      chk("t5_d_blocked", bus.d_req_ready, 0);
      chk("t5_f_stable",  bus.f_rsp_data, init_word(2));
    end
    cycle(0, 0, 1, 1, 0, 32'h20, 0, 1);
    chk("t5_d_accept", bus.d_req_ready, 1);

    // Reset while the D response is held
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_pre_d_rsp_valid", bus.d_rsp_valid, 1);
    bus.f_req_valid = 1; bus.d_req_valid = 1;
    #2;
    rst = 1;
    #1;
    check_zero("t6_async");
    @(posedge clk);
    #1;
    check_zero("t6_held");
    bus.f_req_valid = 0; bus.d_req_valid = 0;
    @(negedge clk);
    rst = 0;
    m_owner = 0; m_starve = 0;
    #1;
    chk("t6_no_stale_d_rsp", bus.d_rsp_valid, 0);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      cycle(1'($urandom_range(0, 1)), rand_addr(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rand_addr(),
            $urandom(), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
